// File: rtl/pipe_alu_regmem_if.sv
// Operation/result bus for pipe_alu_regmem. The master side issues operations and
// debug addresses; the slave side is the pipeline.
interface pipe_alu_regmem_if #(
    parameter int DW     = 16,
    parameter int NREG   = 16,
    parameter int MDEPTH = 256
);
    localparam int RA = $clog2(NREG);
    localparam int MA = $clog2(MDEPTH);

    // Handshake: an operation is taken on a rising edge where in_valid && in_ready.
    // in_ready is simply ~hold; while hold is high nothing anywhere in the pipe moves.
    logic          in_valid;
    logic          in_ready;
    logic          hold;
    logic [RA-1:0] rs1;
    logic [RA-1:0] rs2;
    logic [RA-1:0] rd;
    logic [3:0]    func;
    logic [MA-1:0] addr;

    logic          out_valid;
    logic [DW-1:0] zout;
    logic [RA-1:0] out_rd;
    logic [MA-1:0] out_addr;
    logic          out_err;

    logic [RA-1:0] dbg_raddr;
    logic [DW-1:0] dbg_rdata;
    logic [MA-1:0] dbg_maddr;
    logic [DW-1:0] dbg_mdata;

    modport master (
        output in_valid, hold, rs1, rs2, rd, func, addr, dbg_raddr, dbg_maddr,
        input  in_ready, out_valid, zout, out_rd, out_addr, out_err, dbg_rdata, dbg_mdata
    );

    modport slave (
        input  in_valid, hold, rs1, rs2, rd, func, addr, dbg_raddr, dbg_maddr,
        output in_ready, out_valid, zout, out_rd, out_addr, out_err, dbg_rdata, dbg_mdata
    );
endinterface

// File: rtl/pipe_alu_regmem.sv
// Three-stage register/ALU/memory pipeline: decode latch, forwarded execute,
// regbank writeback, followed by a result store into memory.
module pipe_alu_regmem #(
    parameter int DW     = 16,
    parameter int NREG   = 16,
    parameter int MDEPTH = 256
) (
    input logic              clk,
    input logic              rst_n,
    pipe_alu_regmem_if.slave bus
);
    localparam int RA = $clog2(NREG);
    localparam int MA = $clog2(MDEPTH);

    logic [DW-1:0] regbank [NREG];
    logic [DW-1:0] mem     [MDEPTH];

    // S1
    logic          v1;
    logic [RA-1:0] rs1_1, rs2_1, rd1;
    logic [3:0]    func1;
    logic [MA-1:0] addr1;
    // S2
    logic          v2;
    logic [DW-1:0] z2;
    logic [RA-1:0] rd2;
    logic [MA-1:0] addr2;
    logic          err2;
    // S3
    logic          v3;
    logic [DW-1:0] z3;
    logic [RA-1:0] rd3;
    logic [MA-1:0] addr3;
    logic          err3;

    logic [DW-1:0] op_a, op_b, alu_z;
    logic          alu_err;
    logic          rs1_ok, rs2_ok, rd2_ok, dbg_r_ok, addr3_ok, dbg_m_ok;

    // Indices at or above a non-power-of-two depth read as 0 and never write.
    if (NREG == (1 << RA)) begin : g_reg_full
        assign rs1_ok   = 1'b1;
        assign rs2_ok   = 1'b1;
        assign rd2_ok   = 1'b1;
        assign dbg_r_ok = 1'b1;
    end else begin : g_reg_part
        assign rs1_ok   = 32'(rs1_1) < NREG;
        assign rs2_ok   = 32'(rs2_1) < NREG;
        assign rd2_ok   = 32'(rd2) < NREG;
        assign dbg_r_ok = 32'(bus.dbg_raddr) < NREG;
    end

    if (MDEPTH == (1 << MA)) begin : g_mem_full
        assign addr3_ok = 1'b1;
        assign dbg_m_ok = 1'b1;
    end else begin : g_mem_part
        assign addr3_ok = 32'(addr3) < MDEPTH;
        assign dbg_m_ok = 32'(bus.dbg_maddr) < MDEPTH;
    end

    // The op in S2 is forwarded; anything older has already reached the bank.
    assign op_a = (v2 && rd2_ok && rd2 == rs1_1) ? z2 : (rs1_ok ? regbank[rs1_1] : '0);
    assign op_b = (v2 && rd2_ok && rd2 == rs2_1) ? z2 : (rs2_ok ? regbank[rs2_1] : '0);

    always_comb begin
        alu_z   = '0;
        alu_err = 1'b0;
        case (func1)
            4'd0:  alu_z = op_a + op_b;
            4'd1:  alu_z = op_a - op_b;
            4'd2:  alu_z = op_a * op_b;
            4'd3:  alu_z = op_a;
            4'd4:  alu_z = op_b;
            4'd5:  alu_z = op_a & op_b;
            4'd6: begin
                if (op_b == '0) begin
                    alu_z   = '1;
                    alu_err = 1'b1;
                end else begin
                    alu_z = op_a / op_b;
                end
            end
            4'd7:  alu_z = op_a ^ op_b;
            4'd8:  alu_z = -op_a;
            4'd9:  alu_z = -op_b;
            4'd10: alu_z = {1'b0, op_a[DW-1:1]};
            4'd11: alu_z = {op_a[DW-2:0], 1'b0};
            4'd12: alu_z = {op_a[DW-1], op_a[DW-1:1]};
            4'd13: alu_z = op_a | op_b;
            4'd14: alu_z = ~op_a;
            4'd15: alu_z = {{(DW-1){1'b0}}, (op_a < op_b)};
            default: alu_z = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1    <= 1'b0;
            rs1_1 <= '0;
            rs2_1 <= '0;
            rd1   <= '0;
            func1 <= '0;
            addr1 <= '0;
            v2    <= 1'b0;
            z2    <= '0;
            rd2   <= '0;
            addr2 <= '0;
            err2  <= 1'b0;
            v3    <= 1'b0;
            z3    <= '0;
            rd3   <= '0;
            addr3 <= '0;
            err3  <= 1'b0;
        end else if (!bus.hold) begin
            v1    <= bus.in_valid;
            rs1_1 <= bus.rs1;
            rs2_1 <= bus.rs2;
            rd1   <= bus.rd;
            func1 <= bus.func;
            addr1 <= bus.addr;
            v2    <= v1;
            z2    <= alu_z;
            rd2   <= rd1;
            addr2 <= addr1;
            err2  <= alu_err;
            v3    <= v2;
            z3    <= z2;
            rd3   <= rd2;
            addr3 <= addr2;
            err3  <= err2;
        end
    end

    // Storage is never cleared; v2/v3 are already low during and right after reset.
    always_ff @(posedge clk) begin
        if (!bus.hold && v2 && rd2_ok) regbank[rd2] <= z2;
    end

    always_ff @(posedge clk) begin
        if (!bus.hold && v3 && addr3_ok) mem[addr3] <= z3;
    end

    assign bus.in_ready  = ~bus.hold;
    assign bus.out_valid = v3;
    assign bus.zout      = z3;
    assign bus.out_rd    = rd3;
    assign bus.out_addr  = addr3;
    assign bus.out_err   = err3;
    assign bus.dbg_rdata = dbg_r_ok ? regbank[bus.dbg_raddr] : '0;
    assign bus.dbg_mdata = dbg_m_ok ? mem[bus.dbg_maddr] : '0;
endmodule

// File: tb/tb_pipe_alu_regmem.sv
// Directed bench for pipe_alu_regmem: builds constants through the pipe itself,
// then checks latency, forwarding, the ALU ops, hold and mid-stream reset.
module tb_pipe_alu_regmem;
    localparam int W = 29;

    logic clk;
    logic rst_n;
    int   n_checks = 0;
    int   n_pass   = 0;
    logic [W-1:0] exp_q[$];

    pipe_alu_regmem_if #(.DW(16), .NREG(16), .MDEPTH(256)) bus ();

    pipe_alu_regmem #(.DW(16), .NREG(16), .MDEPTH(256)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // driver tasks
    task automatic issue(input logic [3:0] f, input logic [3:0] a, input logic [3:0] b,
                         input logic [3:0] d, input logic [7:0] ad,
                         input logic [15:0] z, input logic e);
        bus.in_valid = 1'b1;
        bus.func     = f;
        bus.rs1      = a;
        bus.rs2      = b;
        bus.rd       = d;
        bus.addr     = ad;
        exp_q.push_back({e, d, ad, z});
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        bus.in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    // scoreboard: every result that leaves S3 on a moving edge is matched in order
    initial begin
        bit adv;
        forever begin
            @(posedge clk);
            adv = !bus.hold && rst_n;
            @(negedge clk);
            if (adv && bus.out_valid) begin
                if (exp_q.size() == 0) check("out_extra", 32'(bus.out_valid), 32'd0);
                else check("out_seq", 32'({bus.out_err, bus.out_rd, bus.out_addr, bus.zout}),
                           32'(exp_q.pop_front()));
            end
        end
    end

    logic [3:0]  t_f [16] = '{4'd12, 4'd10, 4'd8, 4'd15, 4'd13, 4'd5, 4'd7, 4'd9,
                              4'd4, 4'd11, 4'd14, 4'd1, 4'd2, 4'd3, 4'd0, 4'd6};
    logic [15:0] t_z [16] = '{16'hC001, 16'h4001, 16'h7FFE, 16'h0001, 16'h8003, 16'h8002,
                              16'h0001, 16'h7FFD, 16'h8003, 16'h0004, 16'h7FFD, 16'hFFFF,
                              16'h8006, 16'h8002, 16'h0005, 16'h0000};

    initial begin
        rst_n = 1'b0;
        bus.in_valid  = 1'b0;
        bus.hold      = 1'b0;
        bus.func      = '0;
        bus.rs1       = '0;
        bus.rs2       = '0;
        bus.rd        = '0;
        bus.addr      = '0;
        bus.dbg_raddr = '0;
        bus.dbg_maddr = '0;
        #3;
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_zout", 32'(bus.zout), 32'd0);
        check("rst_out_rd", 32'(bus.out_rd), 32'd0);
        check("rst_out_addr", 32'(bus.out_addr), 32'd0);
        check("rst_out_err", 32'(bus.out_err), 32'd0);
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        #9 rst_n = 1'b1;
        @(posedge clk); #1;

        // constants from an arbitrary bank: r0=0, r1=1, r2=3, then r3=5, r1=5
        issue(4'd7,  4'd0, 4'd0, 4'd0, 8'h00, 16'h0000, 1'b0);
        issue(4'd14, 4'd0, 4'd0, 4'd1, 8'h00, 16'hFFFF, 1'b0);
        issue(4'd8,  4'd1, 4'd0, 4'd1, 8'h00, 16'h0001, 1'b0);
        issue(4'd11, 4'd1, 4'd0, 4'd2, 8'h00, 16'h0002, 1'b0);
        issue(4'd0,  4'd1, 4'd2, 4'd2, 8'h00, 16'h0003, 1'b0);
        issue(4'd0,  4'd2, 4'd1, 4'd3, 8'h00, 16'h0004, 1'b0);
        issue(4'd0,  4'd3, 4'd1, 4'd3, 8'h00, 16'h0005, 1'b0);
        issue(4'd3,  4'd3, 4'd0, 4'd1, 8'h00, 16'h0005, 1'b0);
        idle(4);

        // latency and writeback: r1(5)+r2(3) -> r4, mem[8]
        bus.dbg_raddr = 4'd4;
        bus.dbg_maddr = 8'd8;
        issue(4'd0, 4'd1, 4'd2, 4'd4, 8'h08, 16'h0008, 1'b0);
        bus.in_valid = 1'b0;
        @(posedge clk); @(negedge clk);
        check("lat_e1_valid", 32'(bus.out_valid), 32'd0);
        @(posedge clk); @(negedge clk);
        check("lat_e2_valid", 32'(bus.out_valid), 32'd1);
        check("add_zout", 32'(bus.zout), 32'd8);
        check("add_out_rd", 32'(bus.out_rd), 32'd4);
        check("add_out_addr", 32'(bus.out_addr), 32'd8);
        check("add_regbank4", 32'(bus.dbg_rdata), 32'd8);
        @(posedge clk); @(negedge clk);
        check("add_mem8", 32'(bus.dbg_mdata), 32'd8);
        @(posedge clk); #1;

        // back-to-back dependency
        issue(4'd0, 4'd4, 4'd2, 4'd5, 8'h10, 16'd11, 1'b0);
        issue(4'd2, 4'd5, 4'd2, 4'd6, 8'h11, 16'd33, 1'b0);
        idle(4);
        bus.dbg_raddr = 4'd5;
        #1 check("dep_regbank5", 32'(bus.dbg_rdata), 32'd11);

        // divide: r9=100, /0 then /7
        issue(4'd11, 4'd1, 4'd0, 4'd8,  8'h12, 16'd10, 1'b0);
        issue(4'd11, 4'd8, 4'd0, 4'd8,  8'h12, 16'd20, 1'b0);
        issue(4'd2,  4'd1, 4'd8, 4'd9,  8'h12, 16'h0064, 1'b0);
        issue(4'd6,  4'd9, 4'd0, 4'd10, 8'h13, 16'hFFFF, 1'b1);
        issue(4'd8,  4'd10, 4'd0, 4'd11, 8'h14, 16'h0001, 1'b0);
        issue(4'd1,  4'd4, 4'd11, 4'd12, 8'h14, 16'h0007, 1'b0);
        issue(4'd6,  4'd9, 4'd12, 4'd13, 8'h15, 16'd14, 1'b0);

        // r14 = 0x8000 by shifting 1, then r15 = 0x8002, r14 = 0x8003
        issue(4'd3, 4'd11, 4'd0, 4'd14, 8'h16, 16'h0001, 1'b0);
        for (int i = 0; i < 15; i++)
            issue(4'd11, 4'd14, 4'd0, 4'd14, 8'h16, 16'(1 << (i + 1)), 1'b0);
        issue(4'd11, 4'd11, 4'd0, 4'd15, 8'h17, 16'h0002, 1'b0);
        issue(4'd0,  4'd14, 4'd15, 4'd15, 8'h17, 16'h8002, 1'b0);
        issue(4'd0,  4'd15, 4'd11, 4'd14, 8'h17, 16'h8003, 1'b0);
        for (int i = 0; i < 16; i++)
            issue(t_f[i], 4'd15, 4'd14, 4'd3, 8'(8'h20 + i), t_z[i], 1'b0);
        issue(4'd15, 4'd14, 4'd15, 4'd3, 8'h30, 16'h0000, 1'b0);
        idle(4);

        // hold with A/B/C in flight and D waiting at the input
        issue(4'd3, 4'd9, 4'd0, 4'd7, 8'h08, 16'h0064, 1'b0);
        issue(4'd4, 4'd0, 4'd12, 4'd7, 8'h50, 16'h0007, 1'b0);
        issue(4'd0, 4'd7, 4'd7, 4'd7, 8'h51, 16'd14, 1'b0);
        bus.hold      = 1'b1;
        bus.func      = 4'd7;
        bus.rs1       = 4'd7;
        bus.rs2       = 4'd7;
        bus.rd        = 4'd7;
        bus.addr      = 8'h52;
        bus.in_valid  = 1'b1;
        bus.dbg_raddr = 4'd7;
        bus.dbg_maddr = 8'd8;
        exp_q.push_back({1'b0, 4'd7, 8'h52, 16'h0000});
        repeat (3) begin
            @(negedge clk);
            check("hold_in_ready", 32'(bus.in_ready), 32'd0);
            check("hold_out_valid", 32'(bus.out_valid), 32'd1);
            check("hold_zout", 32'(bus.zout), 32'h64);
            check("hold_out_rd", 32'(bus.out_rd), 32'd7);
            check("hold_regbank7", 32'(bus.dbg_rdata), 32'h64);
            check("hold_mem8", 32'(bus.dbg_mdata), 32'd8);
            @(posedge clk); #1;
        end
        bus.hold = 1'b0;
        #1 check("release_in_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("release_mem8", 32'(bus.dbg_mdata), 32'h64);
        @(posedge clk); #1;
        idle(4);
        check("hold_drain", 32'(exp_q.size()), 32'd0);

        // reset with all three stages full; S3 holds a store of 8 to mem[8]
        issue(4'd3, 4'd4, 4'd0, 4'd5, 8'h08, 16'h0008, 1'b0);
        issue(4'd3, 4'd4, 4'd0, 4'd5, 8'h31, 16'h0008, 1'b0);
        issue(4'd3, 4'd4, 4'd0, 4'd5, 8'h32, 16'h0008, 1'b0);
        bus.in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("mid_rst_zout", 32'(bus.zout), 32'd0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("mid_rst_mem8", 32'(bus.dbg_mdata), 32'h64);
        rst_n = 1'b1;
        @(posedge clk); @(negedge clk);
        check("post_rst_mem8", 32'(bus.dbg_mdata), 32'h64);
        check("post_rst_out_valid", 32'(bus.out_valid), 32'd0);
        @(posedge clk); #1;
        issue(4'd0, 4'd4, 4'd2, 4'd6, 8'h60, 16'd11, 1'b0);
        idle(5);
        bus.dbg_raddr = 4'd6;
        bus.dbg_maddr = 8'h60;
        #1;
        check("post_rst_regbank6", 32'(bus.dbg_rdata), 32'd11);
        check("post_rst_mem60", 32'(bus.dbg_mdata), 32'd11);
        check("final_drain", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/pipe_alu_regmem.md
Name: pipe_alu_regmem

Overview:
Parametrised, single-clock successor to the team's two-phase register/ALU/memory pipeline. It takes one operation per cycle (rs1, rs2, rd, func, addr) and runs it through three stages:
- S1: decode latch.
- S2: operand read with forwarding, ALU execute, result register.
- S3: register-bank writeback and result output.

A trailing memory write stores each result at its addr. Adds a valid/hold handshake, full result forwarding, extra ALU ops, a divide-by-zero flag and debug read ports for the register bank and memory.

Parameters:
DW, 16, data width of registers, ALU and memory words
NREG, 16, number of register-bank entries; RA = clog2(NREG)
MDEPTH, 256, memory words; MA = clog2(MDEPTH)

Ports:
clk  in  1  single clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  operation present on rs1/rs2/rd/func/addr
in_ready  out  1  = ~hold; op accepted on edge where in_valid & in_ready
hold  in  1  freezes every stage register, regbank write and memory write
rs1, rs2, rd  in  RA  source/destination register indices
func  in  4  ALU operation code
addr  in  MA  memory address for result store
out_valid  out  1  zout/out_rd/out_addr/out_err valid (S3 occupied)
zout  out  DW  S3 result
out_rd  out  RA  S3 destination register
out_addr  out  MA  S3 memory address
out_err  out  1  S3 result came from divide by zero
dbg_raddr  in  RA  ; dbg_rdata  out  DW  combinational regbank[dbg_raddr]
dbg_maddr  in  MA  ; dbg_mdata  out  DW  combinational mem[dbg_maddr]

Behaviour:
- Reset (async, rst_n low): v1, v2 and v3 stage valids = 0; zout = 0, out_rd = 0, out_addr = 0, out_err = 0. Regbank and memory are not cleared.
- Reset mid-operation drops all in-flight ops. A pending memory write from S3 does not occur on the release edge.
- All edges below are non-hold edges. With hold = 1, no stage register, regbank entry or memory word changes.
- Accept at edge E0: S1 latches the fields and v1 = 1. If in_valid = 0 at a non-hold edge, v1 = 0 (bubble).
- E1, S1 to S2:
  - Operand A = regbank[rs1], B = regbank[rs2].
  - Forwarding: if v2 and rd2 == rsX, use z2 instead. This applies to both operands independently.
  - Result z2 = f(A, B); rd2, addr2, err2 and v2 = v1 are registered.
- E2, S2 to S3: if v2, regbank[rd2] <= z2. zout/out_rd/out_addr/out_err <= S2 values; out_valid = v2.
- E3: if out_valid, mem[out_addr] <= zout.
- Latency: accept edge to out_valid is 2 edges; the result is visible after E2.
- Throughput: 1 op/cycle with no stalls. Back-to-back dependent ops need no bubbles.
- Debug reads are combinational and reflect the post-edge state. A write in the same cycle is not bypassed.
- ALU, all results truncated to DW bits, operands unsigned unless noted:
  - 0 A+B; 1 A-B (wraps); 2 A*B (low DW bits); 3 A; 4 B; 5 A&B.
  - 6 A/B; if B == 0 then result = all ones and err = 1.
  - 7 A^B; 8 -A; 9 -B (two's complement); 10 A>>1 (logical); 11 A<<1.
  - 12 A>>>1 (arithmetic, sign = A[DW-1]); 13 A|B; 14 ~A; 15 (A<B) ? 1 : 0.
  - err = 0 for every op except 6 with B == 0.
- Simultaneous regbank write (S2 to S3) and S1 read of the same index is covered by forwarding from z2.
- An S3 op whose rd matches the S1 source needs nothing extra; it was already written at the previous edge.
- rd/addr index width is exact, so there is no out-of-range case when NREG/MDEPTH are powers of two. Otherwise indices at or above the depth: write ignored, read returns 0.

Test Plan:
- Preload via ops: r1=5 (set via op 3 chain from preloaded bank), then op0 rs1=1 rs2=2 (r2=3), rd=4, addr=8. The result must satisfy all of:
  - out_valid exactly 2 edges after accept.
  - zout = 8, out_rd = 4, out_addr = 8.
  - regbank[4] = 8.
  - mem[8] = 8 one edge later.
- Back-to-back dependency: with r4 = 8, r2 = 3, op0 rd=5 rs=4,2, then the next cycle op2 rs1=5 rs2=2 → zout sequence 11, 33; dbg regbank[5] = 11.
- Divide: r1 = 0x0064, r2 = 0 → op6 gives zout = 0xFFFF, out_err = 1. Then op6 with r2 = 7 → zout = 14, out_err = 0.
- Arithmetic ops, DW = 16, r1 = 0x8002:
  - op12 → 0xC001.
  - op10 → 0x4001.
  - op8 → 0x7FFE.
  - op15 with r2 = 0x8003 → 1.
- Hold: assert hold for 3 cycles while 3 ops are in flight → in_ready = 0, outputs and dbg values frozen. After release, results emerge in order, one per cycle, none lost or duplicated.
- Reset mid-stream: drop rst_n while v1, v2 and v3 = 1. The following must hold:
  - Immediately: out_valid = 0, zout = 0.
  - The memory word at the pending out_addr is unchanged.
  - After release, the next op completes normally.
